maze_probe: RTL and testbench
=============================

MAZE_PROBE -- requirements
Module: maze_probe

Interface
REQ-001 Parameter SPRITE_W, default 2: probed footprint width in pixels, legal range 1..8.
REQ-002 Parameter SPRITE_H, default 2: probed footprint height in pixels, legal range 1..8.
REQ-003 Parameter SCREEN_W, default 160; parameter SCREEN_H, default 120: maze bitmap size in pixels.
REQ-004 Parameter ROM_LAT, default 1: maze ROM read latency in cycles, legal range 1..3.
REQ-005 Parameter WIN_X, default 148; parameter WIN_Y, default 110: lower-right goal-region origin.
REQ-006 Port clk, input, 1: sole clock, rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port req, input, 1: start a probe; sampled only in IDLE.
REQ-009 Port x_in, input, 8: footprint top-left x. Port y_in, input, 7: footprint top-left y.
REQ-010 Port rom_addr, output, ADDR_W: maze ROM address; ADDR_W = clog2(SCREEN_W*SCREEN_H).
REQ-011 Port rom_q, input, 1: maze ROM data, 1 = wall, valid ROM_LAT cycles after the address.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port done, output, 1: single-cycle pulse; blocked, win and wall_cnt are valid in that cycle.
REQ-014 Port blocked, output, 1: footprint touches a wall or the screen edge.
REQ-015 Port win, output, 1: latched x >= WIN_X and latched y >= WIN_Y.
REQ-016 Port wall_cnt, output, 7: number of wall or out-of-bounds pixels in the footprint.

Function
REQ-017 FSM states: IDLE, SCAN, DRAIN, DONE.
REQ-018 IDLE: when req=1, latch x_in and y_in, clear the accumulators, and go to SCAN.
REQ-019 SCAN: issue one footprint pixel per cycle, row-major from (x,y) to (x+SPRITE_W-1, y+SPRITE_H-1).
REQ-020 SCAN: after the last pixel, go to DRAIN.
REQ-021 DRAIN: wait until all ROM_LAT in-flight reads have returned, then go to DONE.
REQ-022 DONE: assert done for one cycle, then go to IDLE.
REQ-023 Latency: N = SPRITE_W*SPRITE_H; req accepted at edge 0; done is high during cycle N+ROM_LAT+1.
REQ-024 rom_addr = px + SCREEN_W*py, computed at full ADDR_W width with no truncation of the product.
REQ-025 A pixel with px >= SCREEN_W or py >= SCREEN_H counts as a wall.
REQ-026 For an out-of-bounds pixel, rom_addr is driven to 0 and rom_q is ignored for that slot.
REQ-027 Each returned wall pixel increments wall_cnt; blocked = (wall_cnt != 0).
REQ-028 win is computed from the latched coordinates and is held stable until the next accepted req.
REQ-029 req while busy=1 is ignored and is not queued.
REQ-030 req held high through DONE starts a new probe on the IDLE cycle that follows.
REQ-031 blocked, win and wall_cnt hold their values after done until the next accepted req clears them.
REQ-032 rom_addr holds its last value when the FSM is not in SCAN.

Reset
REQ-033 Reset forces IDLE; busy, done, blocked, win and wall_cnt go to 0; rom_addr goes to 0.
REQ-034 Reset asserted mid-SCAN or mid-DRAIN discards all in-flight ROM returns.
REQ-035 No done pulse is produced for an aborted probe.

Configuration
REQ-036 Macro MAZE_PROBE_EARLY_EXIT_EN defined: the first wall or out-of-bounds pixel ends SCAN and enters DRAIN.
REQ-037 With MAZE_PROBE_EARLY_EXIT_EN defined, wall_cnt saturates at 1 and latency becomes variable.
REQ-038 MAZE_PROBE_EARLY_EXIT_EN undefined: the full footprint is always scanned with the fixed latency of REQ-023.

Structure
REQ-039 Shared package maze_pkg: FSM state enum, SCREEN_W/SCREEN_H defaults, ADDR_W function, WIN_X/WIN_Y defaults.
REQ-040 Sub-module maze_addr_gen: footprint x/y counters, bounds flag and address multiply-add.
REQ-041 maze_probe: FSM, ROM_LAT-deep valid/out-of-bounds shift pipeline, accumulators.

Verification
REQ-042 Defaults, req at (10,10), wall-free ROM -> addresses 1610,1611,1770,1771; done at cycle 6; blocked=0; wall_cnt=0.
REQ-043 Wall at only (11,11), req at (10,10) -> blocked=1, wall_cnt=1.
REQ-044 req at (159,119) -> 3 out-of-bounds pixels; wall_cnt=3; only address 19199 issued as non-zero.
REQ-045 req at (148,110) -> win=1; req at (147,110) -> win=0.
REQ-046 Reset pulsed in the 2nd SCAN cycle -> no done; all outputs 0; next req completes normally.
REQ-047 SPRITE_W=4, SPRITE_H=3, ROM_LAT=3, req pulsed during busy -> ignored; done exactly at cycle 16.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: shared FSM states, maze geometry defaults and address-width helper
package maze_pkg;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;
  localparam int WIN_X_DEF = 148;
  localparam int WIN_Y_DEF = 110;
  function automatic int addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction
endpackage

// File: rtl/maze_addr_gen.sv
// maze_addr_gen: footprint x/y walk, bounds flag and row-major maze address
module maze_addr_gen import maze_pkg::*; #(
  parameter int SPRITE_W = 2,
  parameter int SPRITE_H = 2,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  localparam int ADDR_W = addr_w(SCREEN_W, SCREEN_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic [7:0]        x_in,
  input  logic [6:0]        y_in,
  output logic [ADDR_W-1:0] addr,
  output logic              oob,
  output logic              last
);
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] cx_q, cx_d, cy_q, cy_d;
  logic [8:0] px;
  logic [7:0] py;
  logic       row_end;
  always_comb begin
    row_end = cx_q == 3'(SPRITE_W - 1);
    x_d = start ? x_in : x_q;
    y_d = start ? y_in : y_q;
    cx_d = start ? 3'd0 : step ? (row_end ? 3'd0 : cx_q + 3'd1) : cx_q;
    cy_d = start ? 3'd0 : (step && row_end) ? cy_q + 3'd1 : cy_q;
    // widened sums so coordinates past the screen edge never wrap back inside
    px = {1'b0, x_q} + {6'd0, cx_q};
    py = {1'b0, y_q} + {5'd0, cy_q};
    oob = 32'(px) >= SCREEN_W || 32'(py) >= SCREEN_H;
    addr = ADDR_W'(px) + ADDR_W'(SCREEN_W) * ADDR_W'(py);
    last = row_end && cy_q == 3'(SPRITE_H - 1);
  end
  always_ff @(posedge clk)
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
endmodule

// File: rtl/maze_probe.sv
// maze_probe: scans a sprite footprint against the maze ROM and reports walls/goal.
// Define MAZE_PROBE_EARLY_EXIT_EN to stop scanning at the first wall or off-screen pixel.
module maze_probe import maze_pkg::*; #(
  parameter int SPRITE_W = 2,
  parameter int SPRITE_H = 2,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF,
  parameter int ROM_LAT = 1,
  parameter int WIN_X = WIN_X_DEF,
  parameter int WIN_Y = WIN_Y_DEF,
  localparam int ADDR_W = addr_w(SCREEN_W, SCREEN_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [7:0]        x_in,
  input  logic [6:0]        y_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic              rom_q,
  output logic              busy,
  output logic              done,
  output logic              blocked,
  output logic              win,
  output logic [6:0]        wall_cnt
);
  state_t              state_q, state_d;
  logic [ROM_LAT:0]    v_q, v_d, o_q, o_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d, addr;
  logic [6:0]          wall_cnt_q, wall_cnt_d;
  logic                win_q, win_d;
  logic                accept, issue, ret_hit, stop, oob, last;
  maze_addr_gen #(
    .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H), .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)
  ) u_addr (
    .clk(clk), .reset(reset), .start(accept), .step(issue), .x_in(x_in), .y_in(y_in),
    .addr(addr), .oob(oob), .last(last)
  );
  always_comb begin
    accept = state_q == IDLE && req;
    issue = state_q == SCAN;
    // one stage for the registered address plus ROM_LAT stages of ROM latency
    ret_hit = v_q[ROM_LAT] & (o_q[ROM_LAT] | rom_q);
    v_d = {v_q[ROM_LAT-1:0], issue};
    o_d = {o_q[ROM_LAT-1:0], issue & oob};
    rom_addr_d = issue ? (oob ? '0 : addr) : rom_addr_q;
    win_d = accept ? (32'(x_in) >= WIN_X && 32'(y_in) >= WIN_Y) : win_q;
`ifdef MAZE_PROBE_EARLY_EXIT_EN
    wall_cnt_d = accept ? 7'd0 : ret_hit ? 7'd1 : wall_cnt_q;
    stop = last | oob | ret_hit;
`else
    wall_cnt_d = accept ? 7'd0 : wall_cnt_q + 7'(ret_hit);
    stop = last;
`endif
    state_d = state_q == IDLE  ? (accept ? SCAN : IDLE) :
              state_q == SCAN  ? (stop ? DRAIN : SCAN) :
              state_q == DRAIN ? (v_d == '0 ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      v_q <= '0;
      o_q <= '0;
      rom_addr_q <= '0;
      wall_cnt_q <= '0;
      win_q <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q <= v_d;
      o_q <= o_d;
      rom_addr_q <= rom_addr_d;
      wall_cnt_q <= wall_cnt_d;
      win_q <= win_d;
    end
  assign rom_addr = rom_addr_q;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign blocked = wall_cnt_q != 7'd0;
  assign win = win_q;
  assign wall_cnt = wall_cnt_q;
endmodule

// File: tb/tb_maze_probe.sv
// tb_maze_probe: table, random and corner-sequence checks of maze_probe against a footprint model
module tb_maze_probe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset, req, rom_q, busy, done, blocked, win;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [14:0] rom_addr;
  logic [6:0] wall_cnt;
  logic req2, rom_q2, busy2, done2, blocked2, win2;
  logic [7:0] x2;
  logic [6:0] y2;
  logic [14:0] rom_addr2;
  logic [6:0] wall_cnt2;
  int n_checks = 0, n_fail = 0;
  bit wall_map [int];
  int last_addrs [$];

  maze_probe dut (
    .clk(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in), .rom_addr(rom_addr),
    .rom_q(rom_q), .busy(busy), .done(done), .blocked(blocked), .win(win), .wall_cnt(wall_cnt)
  );
  maze_probe #(.SPRITE_W(4), .SPRITE_H(3), .ROM_LAT(3)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .x_in(x2), .y_in(y2), .rom_addr(rom_addr2),
    .rom_q(rom_q2), .busy(busy2), .done(done2), .blocked(blocked2), .win(win2), .wall_cnt(wall_cnt2)
  );

  // synchronous ROM, one cycle latency
  always @(posedge clk) rom_q <= wall_map.exists(int'(rom_addr)) != 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic run_probe(input int x, input int y, input string nm);
    int exp_addr [$];
    int ec = 0, de = -1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        int px = x + c, py = y + r;
        if (px >= 160 || py >= 120) begin
          ec++;
          exp_addr.push_back(0);
        end else begin
          exp_addr.push_back(px + 160 * py);
          if (wall_map.exists(px + 160 * py)) ec++;
        end
      end
    last_addrs.delete();
    @(posedge clk); #1 req = 1'b1; x_in = 8'(x); y_in = 7'(y);
    @(posedge clk); #1 req = 1'b0;
    for (int e = 1; e <= 40 && de < 0; e++) begin
      @(posedge clk); #1;
      if (e <= 4) last_addrs.push_back(int'(rom_addr));
      if (done) de = e;
    end
    chk({nm, "_done_cycle"}, de, 6);
    for (int i = 0; i < 4; i++) chk($sformatf("%s_addr%0d", nm, i), last_addrs[i], exp_addr[i]);
    chk({nm, "_wall_cnt"}, int'(wall_cnt), ec);
    chk({nm, "_blocked"}, int'(blocked), int'(ec != 0));
    chk({nm, "_win"}, int'(win), int'(x >= 148 && y >= 110));
  endtask

  typedef struct {int x; int y; int wx; int wy; int cnt; bit w;} vec_t;
  vec_t tbl [10];

  initial begin
    int de, de2, seen, xs, ys, hold_cnt;
    tbl = '{
      '{10, 10, -1, -1, 0, 0}, '{10, 10, 11, 11, 1, 0}, '{159, 119, 0, 0, 3, 1},
      '{148, 110, -1, -1, 0, 1}, '{147, 110, -1, -1, 0, 0}, '{0, 0, 0, 0, 1, 0},
      '{255, 127, -1, -1, 4, 1}, '{158, 118, 159, 119, 1, 1}, '{148, 109, -1, -1, 0, 0},
      '{10, 10, 10, 10, 1, 0}};
    reset = 1'b1; req = 1'b0; x_in = '0; y_in = '0;
    req2 = 1'b0; rom_q2 = 1'b0; x2 = '0; y2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_blocked", int'(blocked), 0);
    chk("rst_win", int'(win), 0);
    chk("rst_wall_cnt", int'(wall_cnt), 0);
    chk("rst_rom_addr", int'(rom_addr), 0);
    chk("rst_busy2", int'(busy2), 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      wall_map.delete();
      if (tbl[i].wx >= 0) wall_map[tbl[i].wx + 160 * tbl[i].wy] = 1'b1;
      run_probe(tbl[i].x, tbl[i].y, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_exp_cnt", i), int'(wall_cnt), tbl[i].cnt);
      chk($sformatf("tbl%0d_exp_win", i), int'(win), int'(tbl[i].w));
      hold_cnt = int'(wall_cnt);
      repeat (3) @(posedge clk);
      #1 chk($sformatf("tbl%0d_hold", i), int'(wall_cnt), tbl[i].cnt);
      chk($sformatf("tbl%0d_hold_blk", i), int'(blocked), int'(hold_cnt != 0));
    end
    wall_map.delete();
    run_probe(10, 10, "lit");
    chk("lit_a0", last_addrs[0], 1610);
    chk("lit_a3", last_addrs[3], 1771);

    for (int k = 0; k < 25; k++) begin
      wall_map.delete();
      xs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(156, 161)) : int'($urandom_range(0, 255));
      ys = ($urandom_range(0, 3) == 0) ? int'($urandom_range(116, 121)) : int'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 1) wall_map[0] = 1'b1;
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++)
          if (xs + c < 160 && ys + r < 120 && $urandom_range(0, 2) == 0)
            wall_map[xs + c + 160 * (ys + r)] = 1'b1;
      run_probe(xs, ys, $sformatf("rnd%0d", k));
    end

    // reset during the second scan cycle aborts the probe
    wall_map.delete();
    wall_map[150 + 160 * 115] = 1'b1;
    @(posedge clk); #1 req = 1'b1; x_in = 8'd150; y_in = 7'd115;
    @(posedge clk); #1 req = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    seen = 0;
    for (int e = 0; e < 10; e++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_wall_cnt", int'(wall_cnt), 0);
    chk("abort_blocked", int'(blocked), 0);
    chk("abort_win", int'(win), 0);
    chk("abort_rom_addr", int'(rom_addr), 0);
    run_probe(150, 115, "after_abort");

    // req held high through DONE restarts on the following IDLE cycle
    wall_map.delete();
    @(posedge clk); #1 req = 1'b1; x_in = 8'd20; y_in = 7'd20;
    @(posedge clk);
    de = -1; de2 = -1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (done && de < 0) de = e;
      else if (done && de2 < 0) de2 = e;
      if (de > 0 && e == de + 1) chk("held_idle_gap", int'(busy), 0);
      if (de > 0 && e == de + 2) begin
        chk("held_restart", int'(busy), 1);
        req = 1'b0;
      end
    end
    req = 1'b0;
    chk("held_done1", de, 6);
    chk("held_done2", de2, 14);
    chk("held_no_third", int'(busy), 0);

    // 4x3 footprint, three-cycle ROM, req pulses while busy are dropped
    @(posedge clk); #1 req2 = 1'b1; x2 = 8'd30; y2 = 7'd40;
    @(posedge clk); #1 req2 = 1'b0;
    de = -1; seen = 0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      req2 = (e == 3 || e == 9 || e == 15);
      if (de > 0 && busy2) seen = 1;
      if (done2 && de < 0) de = e;
    end
    chk("big_done_cycle", de, 16);
    chk("big_no_requeue", seen, 0);
    chk("big_wall_cnt", int'(wall_cnt2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
